// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared 16:1 output channel.
// Holds a grant for up to MAX_BURST handshakes, then rotates.
module mux_rr_scheduler #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DEPTH-1:0]       req,
  input  logic [DEPTH*WIDTH-1:0] i,
  output logic [DEPTH-1:0]       ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [3:0]             sel,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] words [DEPTH];
  logic             found;
  logic [3:0]       pick;
  logic [3:0]       idx;
  logic             hs;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    assign words[g] = i[g*WIDTH +: WIDTH];
  end

  // First requester at or after ptr, wrapping mod 16.
  always_comb begin
    found = 1'b0;
    pick  = 4'd0;
    idx   = 4'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ptr_q + 4'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack       = '0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = GRANT;
          sel_d   = pick;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        busy      = 1'b1;
        out_valid = req[sel_q];
        hs        = out_valid && out_ready;
        if (out_valid)
          out_data = words[sel_q];
        ack[sel_q] = hs;
        if (!req[sel_q] || (hs && cnt_q == LAST)) begin
          ptr_d   = sel_q + 4'd1;
          state_d = IDLE;
        end else if (hs) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      ptr_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = sel_q;

endmodule
